// File: rtl/block_mm_pkg.sv
// Shared constants and types for the 4x32 block multiplier operand feeder.
// Lane geometry, step counts, FSM encoding and write-address fields.
package block_mm_pkg;

  localparam int BIT_WIDTH_DEF  = 16;
  localparam int FRAC_WIDTH_DEF = 8;

  localparam int LANES      = 8;
  localparam int DIM        = 4;
  localparam int SKEW_STEPS = 7;
  localparam int WORDS      = 32;
  localparam int T_W        = 5;
  localparam int MAX_FLUSH  = 24;

  localparam int   ADDR_W       = 6;
  localparam int   ADDR_SEL_BIT = 5;
  localparam int   IDX_MSB      = 4;
  localparam logic SEL_A        = 1'b0;
  localparam logic SEL_B        = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/block_feeder_4x32_if.sv
// Loader/consumer-side bus of the operand feeder.
// master = tile loader / consumer, slave = feeder.
interface block_feeder_4x32_if #(
  parameter int BW = 16
);

  logic          wr_valid;
  logic          wr_ready;
  logic [5:0]    wr_addr;
  logic [4*BW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic          out_valid;
  logic          done;

  logic [4*BW-1:0] north_out0;
  logic [4*BW-1:0] north_out1;
  logic [4*BW-1:0] north_out2;
  logic [4*BW-1:0] north_out3;
  logic [4*BW-1:0] north_out4;
  logic [4*BW-1:0] north_out5;
  logic [4*BW-1:0] north_out6;
  logic [4*BW-1:0] north_out7;

  logic [4*BW-1:0] west_out0;
  logic [4*BW-1:0] west_out1;
  logic [4*BW-1:0] west_out2;
  logic [4*BW-1:0] west_out3;
  logic [4*BW-1:0] west_out4;
  logic [4*BW-1:0] west_out5;
  logic [4*BW-1:0] west_out6;
  logic [4*BW-1:0] west_out7;

  modport master (
    output wr_valid, wr_addr, wr_data, start,
    input  wr_ready, busy, out_valid, done,
    input  north_out0, north_out1, north_out2, north_out3,
    input  north_out4, north_out5, north_out6, north_out7,
    input  west_out0, west_out1, west_out2, west_out3,
    input  west_out4, west_out5, west_out6, west_out7
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, start,
    output wr_ready, busy, out_valid, done,
    output north_out0, north_out1, north_out2, north_out3,
    output north_out4, north_out5, north_out6, north_out7,
    output west_out0, west_out1, west_out2, west_out3,
    output west_out4, west_out5, west_out6, west_out7
  );

endinterface

// File: rtl/block_feeder_4x32_lane.sv
// One 4x4 lane: diagonal skew of four A words and four B words.
// Row r / column c carries element (t-r) / word (t-c) while in range.
module lane_skew_4x4
  import block_mm_pkg::*;
#(
  parameter int BW = BIT_WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            active,
  input  logic [T_W-1:0]  t,
  input  logic [4*BW-1:0] a_word [DIM],
  input  logic [4*BW-1:0] b_word [DIM],
  output logic [4*BW-1:0] west,
  output logic [4*BW-1:0] north
);

  logic [4*BW-1:0] west_d, west_q;
  logic [4*BW-1:0] north_d, north_q;

  function automatic logic [BW-1:0] elem(
    input logic [4*BW-1:0] w,
    input logic [1:0]      i
  );
    return w[(DIM-1-int'(i))*BW +: BW];
  endfunction

  // Select the skewed element per row/column; zero outside the window.
  always_comb begin
    west_d  = '0;
    north_d = '0;
    if (active) begin
      for (int r = 0; r < DIM; r++) begin
        if (t >= T_W'(r) &&
            (t - T_W'(r)) <= T_W'(DIM-1)) begin
          west_d[(DIM-1-r)*BW +: BW] =
            elem(a_word[r], 2'(t - T_W'(r)));
          north_d[(DIM-1-r)*BW +: BW] =
            elem(b_word[2'(t - T_W'(r))], 2'(r));
        end
      end
    end
  end

  // Register the vectors so they align with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      west_q  <= '0;
      north_q <= '0;
    end else begin
      west_q  <= west_d;
      north_q <= north_d;
    end
  end

  assign west  = west_q;
  assign north = north_q;

endmodule

// File: rtl/block_feeder_4x32.sv
// Operand feeder for the 8-lane 4x32 block multiplier.
// Buffers A/B tiles, streams them skewed, zero-flushes, pulses done.
module block_feeder_4x32
  import block_mm_pkg::*;
#(
  parameter int BIT_WIDTH    = BIT_WIDTH_DEF,
  parameter int FRAC_WIDTH   = FRAC_WIDTH_DEF,
  parameter int FLUSH_CYCLES = 9
) (
  input logic clk,
  input logic rst_n,
  block_feeder_4x32_if.slave bus
);

  localparam int VW = DIM * BIT_WIDTH;

  localparam logic [T_W-1:0] T_STREAM_LAST =
    T_W'(SKEW_STEPS - 1);
  localparam logic [T_W-1:0] T_FLUSH_LAST =
    T_W'(SKEW_STEPS - 1 + FLUSH_CYCLES);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > MAX_FLUSH) begin : g_bad_flush
    $error("FLUSH_CYCLES must be in 1..24");
  end

  if (FRAC_WIDTH < 0 || FRAC_WIDTH >= BIT_WIDTH) begin : g_bad_frac
    $error("FRAC_WIDTH must be below BIT_WIDTH");
  end

  state_e         state_d, state_q;
  logic [T_W-1:0] t_d, t_q;
  logic           out_valid_d, out_valid_q;
  logic           done_d, done_q;
  logic           busy_d, busy_q;

  logic [VW-1:0] a_mem_d [WORDS];
  logic [VW-1:0] a_mem_q [WORDS];
  logic [VW-1:0] b_mem_d [WORDS];
  logic [VW-1:0] b_mem_q [WORDS];

  logic [VW-1:0] west_v  [LANES];
  logic [VW-1:0] north_v [LANES];

  logic idle;
  logic wr_fire;
  logic wr_a;
  logic wr_b;
  logic start_fire;
  logic stream_act;

  // The done cycle still counts as busy, so a start there is dropped.
  assign idle       = (state_q == ST_IDLE) && !busy_q;
  assign wr_fire    = bus.wr_valid && idle;
  assign start_fire = bus.start && idle;
  assign stream_act = (state_q == ST_STREAM);

  assign wr_a = wr_fire &&
    (bus.wr_addr[ADDR_SEL_BIT] == SEL_A);
  assign wr_b = wr_fire &&
    (bus.wr_addr[ADDR_SEL_BIT] == SEL_B);

  // Next state, step counter and registered status flags.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    out_valid_d = (state_q == ST_STREAM) ||
                  (state_q == ST_FLUSH);
    done_d      = (state_q == ST_DONE);
    busy_d      = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (start_fire) begin
          state_d = ST_STREAM;
          t_d     = '0;
        end
      end
      ST_STREAM: begin
        t_d = t_q + T_W'(1);
        if (t_q == T_STREAM_LAST) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (t_q == T_FLUSH_LAST) begin
          state_d = ST_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // FSM and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Tile write port: address bit 5 picks the A or B buffer.
  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    unique case (1'b1)
      wr_a: a_mem_d[bus.wr_addr[IDX_MSB:0]] = bus.wr_data;
      wr_b: b_mem_d[bus.wr_addr[IDX_MSB:0]] = bus.wr_data;
      default: ;
    endcase
  end

  // Tile storage, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mem_q <= '{default: '0};
      b_mem_q <= '{default: '0};
    end else begin
      a_mem_q <= a_mem_d;
      b_mem_q <= b_mem_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [VW-1:0] a_w [DIM];
    logic [VW-1:0] b_w [DIM];

    for (genvar i = 0; i < DIM; i++) begin : g_sel
      assign a_w[i] = a_mem_q[LANES*i + k];
      assign b_w[i] = b_mem_q[DIM*k + i];
    end

    lane_skew_4x4 #(
      .BW(BIT_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .active (stream_act),
      .t      (t_q),
      .a_word (a_w),
      .b_word (b_w),
      .west   (west_v[k]),
      .north  (north_v[k])
    );
  end

  assign bus.wr_ready  = idle;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;

  assign bus.west_out0 = west_v[0];
  assign bus.west_out1 = west_v[1];
  assign bus.west_out2 = west_v[2];
  assign bus.west_out3 = west_v[3];
  assign bus.west_out4 = west_v[4];
  assign bus.west_out5 = west_v[5];
  assign bus.west_out6 = west_v[6];
  assign bus.west_out7 = west_v[7];

  assign bus.north_out0 = north_v[0];
  assign bus.north_out1 = north_v[1];
  assign bus.north_out2 = north_v[2];
  assign bus.north_out3 = north_v[3];
  assign bus.north_out4 = north_v[4];
  assign bus.north_out5 = north_v[5];
  assign bus.north_out6 = north_v[6];
  assign bus.north_out7 = north_v[7];

endmodule

// File: tb/tb_block_feeder_4x32.sv
// Directed and random checks of the 4x32 operand feeder.
// Skew, timing, handshake, reset and an A x B systolic model.
module tb_block_feeder_4x32;

  logic clk;
  logic rst_n;

  block_feeder_4x32_if #(.BW(16)) bus ();

  block_feeder_4x32 #(
    .BIT_WIDTH    (16),
    .FRAC_WIDTH   (8),
    .FLUSH_CYCLES (9)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] west_a  [8];
  logic [63:0] north_a [8];

  assign west_a[0] = bus.west_out0;
  assign west_a[1] = bus.west_out1;
  assign west_a[2] = bus.west_out2;
  assign west_a[3] = bus.west_out3;
  assign west_a[4] = bus.west_out4;
  assign west_a[5] = bus.west_out5;
  assign west_a[6] = bus.west_out6;
  assign west_a[7] = bus.west_out7;
  assign north_a[0] = bus.north_out0;
  assign north_a[1] = bus.north_out1;
  assign north_a[2] = bus.north_out2;
  assign north_a[3] = bus.north_out3;
  assign north_a[4] = bus.north_out4;
  assign north_a[5] = bus.north_out5;
  assign north_a[6] = bus.north_out6;
  assign north_a[7] = bus.north_out7;

  int checks;
  int failures;

  logic [63:0] cap_w [16][8];
  logic [63:0] cap_n [16][8];
  int ov_cnt, done_cnt, busy_cnt, first_ov, done_idx;
  int rdy_busy, nz_idle, rdy_at_wr, rdy_start;

  logic [15:0] ma [4][32];
  logic [15:0] mb [32][4];

  function automatic logic [63:0] pk(
    input logic [15:0] e0, input logic [15:0] e1,
    input logic [15:0] e2, input logic [15:0] e3);
    return {e0, e1, e2, e3};
  endfunction

  function automatic logic [15:0] el(
    input logic [63:0] w, input int i);
    return w[(3-i)*16 +: 16];
  endfunction

  function automatic int any_nz();
    int n = 0;
    for (int k = 0; k < 8; k++)
      if (west_a[k] != 64'd0 || north_a[k] != 64'd0) n++;
    return n;
  endfunction

  function automatic logic [63:0] exp_west(input int k, input int t);
    logic [15:0] e [4];
    for (int r = 0; r < 4; r++) begin
      e[r] = 16'd0;
      if (t - r >= 0 && t - r <= 3) e[r] = ma[r][4*k + t - r];
    end
    return pk(e[0], e[1], e[2], e[3]);
  endfunction

  function automatic logic [63:0] exp_north(input int k, input int t);
    logic [15:0] e [4];
    for (int c = 0; c < 4; c++) begin
      e[c] = 16'd0;
      if (t - c >= 0 && t - c <= 3) e[c] = mb[4*k + t - c][c];
    end
    return pk(e[0], e[1], e[2], e[3]);
  endfunction

  task automatic write_word(input logic [5:0] a, input logic [63:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic run_capture(
    input int restart_at, input int wr_at, input logic [63:0] wd_busy,
    input bit wr_with_start, input logic [63:0] wd_start);
    ov_cnt = 0; done_cnt = 0; busy_cnt = 0; first_ov = -1;
    done_idx = -1; rdy_busy = 0; nz_idle = 0; rdy_at_wr = -1;
    for (int s = 0; s < 16; s++)
      for (int k = 0; k < 8; k++) begin
        cap_w[s][k] = '0;
        cap_n[s][k] = '0;
      end
    bus.start = 1'b1;
    if (wr_with_start) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 6'd0;
      bus.wr_data  = wd_start;
    end
    rdy_start = int'(bus.wr_ready);
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (ov_cnt < 16)
          for (int k = 0; k < 8; k++) begin
            cap_w[ov_cnt][k] = west_a[k];
            cap_n[ov_cnt][k] = north_a[k];
          end
        if (first_ov < 0) first_ov = n;
        ov_cnt++;
      end else if (any_nz() != 0) begin
        nz_idle++;
      end
      if (bus.done) begin
        done_cnt++;
        done_idx = n;
      end
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.wr_ready) rdy_busy++;
      bus.start = (n == restart_at);
      bus.wr_valid = 1'b0;
      if (n == wr_at) begin
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 6'd0;
        bus.wr_data  = wd_busy;
        rdy_at_wr    = int'(bus.wr_ready);
      end
    end
    bus.start = 1'b0;
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b want=0", bus.done);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=0", bus.busy);
    end
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_wr_ready got=%b want=1", bus.wr_ready);
    end
    checks++;
    if (any_nz() !== 0) begin
      failures++;
      $display("FAIL reset_vectors nonzero_lanes=%0d want=0", any_nz());
    end
  endtask

  task automatic test_a_skew();
    int nz = 0;
    write_word(6'd0,  pk(16'h0100, 16'h0200, 16'h0300, 16'h0400));
    write_word(6'd8,  pk(16'h0500, 16'h0600, 16'h0700, 16'h0800));
    write_word(6'd24, pk(16'h0D00, 16'h0E00, 16'h0F00, 16'h1000));
    run_capture(-1, -1, 64'd0, 1'b0, 64'd0);
    checks++;
    if (cap_w[0][0] !== pk(16'h0100, 0, 0, 0)) begin
      failures++;
      $display("FAIL a_skew_t0 got=%h want=%h", cap_w[0][0],
               pk(16'h0100, 0, 0, 0));
    end
    checks++;
    if (cap_w[1][0] !== pk(16'h0200, 16'h0500, 0, 0)) begin
      failures++;
      $display("FAIL a_skew_t1 got=%h want=%h", cap_w[1][0],
               pk(16'h0200, 16'h0500, 0, 0));
    end
    checks++;
    if (cap_w[3][0] !== pk(16'h0400, 16'h0700, 0, 16'h0D00)) begin
      failures++;
      $display("FAIL a_skew_t3 got=%h want=%h", cap_w[3][0],
               pk(16'h0400, 16'h0700, 0, 16'h0D00));
    end
    checks++;
    if (cap_w[6][0] !== pk(0, 0, 0, 16'h1000)) begin
      failures++;
      $display("FAIL a_skew_t6 got=%h want=%h", cap_w[6][0],
               pk(0, 0, 0, 16'h1000));
    end
    for (int s = 0; s < 16; s++)
      for (int k = 1; k < 8; k++)
        if (cap_w[s][k] != 64'd0) nz++;
    checks++;
    if (nz !== 0) begin
      failures++;
      $display("FAIL a_skew_other_lanes nonzero=%0d want=0", nz);
    end
  endtask

  task automatic test_b_skew();
    int nz = 0;
    for (int j = 28; j < 32; j++)
      write_word(6'(32 + j), pk(16'(j), 16'(j + 'h40),
                               16'(j + 'h80), 16'(j + 'hC0)));
    run_capture(-1, -1, 64'd0, 1'b0, 64'd0);
    checks++;
    if (cap_n[0][7] !== pk(16'h001C, 0, 0, 0)) begin
      failures++;
      $display("FAIL b_skew_t0 got=%h want=%h", cap_n[0][7],
               pk(16'h001C, 0, 0, 0));
    end
    checks++;
    if (cap_n[3][7] !== pk(16'h001F, 16'h005E, 16'h009D, 16'h00DC)) begin
      failures++;
      $display("FAIL b_skew_t3 got=%h want=%h", cap_n[3][7],
               pk(16'h001F, 16'h005E, 16'h009D, 16'h00DC));
    end
    checks++;
    if (cap_n[6][7] !== pk(0, 0, 0, 16'h00DF)) begin
      failures++;
      $display("FAIL b_skew_t6 got=%h want=%h", cap_n[6][7],
               pk(0, 0, 0, 16'h00DF));
    end
    for (int s = 0; s < 16; s++)
      for (int k = 0; k < 7; k++)
        if (cap_n[s][k] != 64'd0) nz++;
    checks++;
    if (nz !== 0) begin
      failures++;
      $display("FAIL b_skew_other_lanes nonzero=%0d want=0", nz);
    end
  endtask

  task automatic test_back_to_back();
    run_capture(16, -1, 64'd0, 1'b0, 64'd0);
    checks++;
    if (first_ov !== 0) begin
      failures++;
      $display("FAIL timing_first_valid got=%0d want=0", first_ov);
    end
    checks++;
    if (ov_cnt !== 16) begin
      failures++;
      $display("FAIL timing_valid_cycles got=%0d want=16", ov_cnt);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL timing_done_cycles got=%0d want=1", done_cnt);
    end
    checks++;
    if (done_idx !== 16) begin
      failures++;
      $display("FAIL timing_done_pos got=%0d want=16", done_idx);
    end
    checks++;
    if (busy_cnt !== 17) begin
      failures++;
      $display("FAIL timing_busy_cycles got=%0d want=17", busy_cnt);
    end
    checks++;
    if (rdy_busy !== 0) begin
      failures++;
      $display("FAIL timing_ready_while_busy got=%0d want=0", rdy_busy);
    end
    checks++;
    if (nz_idle !== 0) begin
      failures++;
      $display("FAIL timing_idle_vectors got=%0d want=0", nz_idle);
    end
  endtask

  task automatic test_handshake();
    logic [63:0] nw, bad;
    nw  = pk(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    bad = pk(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
    run_capture(-1, 3, bad, 1'b1, nw);
    checks++;
    if (rdy_start !== 1) begin
      failures++;
      $display("FAIL hs_ready_idle got=%0d want=1", rdy_start);
    end
    checks++;
    if (cap_w[0][0] !== pk(16'h1111, 0, 0, 0)) begin
      failures++;
      $display("FAIL hs_start_write got=%h want=%h", cap_w[0][0],
               pk(16'h1111, 0, 0, 0));
    end
    checks++;
    if (rdy_at_wr !== 0) begin
      failures++;
      $display("FAIL hs_ready_busy got=%0d want=0", rdy_at_wr);
    end
    run_capture(-1, -1, 64'd0, 1'b0, 64'd0);
    checks++;
    if (cap_w[0][0] !== pk(16'h1111, 0, 0, 0)) begin
      failures++;
      $display("FAIL hs_dropped_t0 got=%h want=%h", cap_w[0][0],
               pk(16'h1111, 0, 0, 0));
    end
    checks++;
    if (cap_w[3][0] !== pk(16'h4444, 16'h0700, 0, 16'h0D00)) begin
      failures++;
      $display("FAIL hs_dropped_t3 got=%h want=%h", cap_w[3][0],
               pk(16'h4444, 16'h0700, 0, 16'h0D00));
    end
  endtask

  task automatic test_reset_midrun();
    int dn = 0, ov = 0, nz = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_valid got=%b want=1", bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.done, bus.busy, bus.wr_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL rst_async_flags got=%b want=0001",
               {bus.out_valid, bus.done, bus.busy, bus.wr_ready});
    end
    checks++;
    if (any_nz() !== 0) begin
      failures++;
      $display("FAIL rst_async_vectors got=%0d want=0", any_nz());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.done) dn++;
      if (bus.out_valid) ov++;
    end
    checks++;
    if (dn !== 0 || ov !== 0) begin
      failures++;
      $display("FAIL rst_no_done done=%0d valid=%0d want=0", dn, ov);
    end
    run_capture(-1, -1, 64'd0, 1'b0, 64'd0);
    for (int s = 0; s < 16; s++)
      for (int k = 0; k < 8; k++)
        if (cap_w[s][k] != 64'd0 || cap_n[s][k] != 64'd0) nz++;
    checks++;
    if (nz !== 0 || ov_cnt !== 16) begin
      failures++;
      $display("FAIL rst_storage_clear nonzero=%0d valid=%0d want=0/16",
               nz, ov_cnt);
    end
  endtask

  task automatic test_random();
    logic [15:0] acc [4][4];
    logic [15:0] ref_v;
    int bad_k;
    for (int run = 0; run < 50; run++) begin
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 32; j++) begin
          ma[r][j] = 16'($urandom);
          mb[j][r] = 16'($urandom);
        end
      for (int w = 0; w < 32; w++)
        write_word(6'(w), pk(ma[w/8][4*(w%8)], ma[w/8][4*(w%8)+1],
                             ma[w/8][4*(w%8)+2], ma[w/8][4*(w%8)+3]));
      for (int j = 0; j < 32; j++)
        write_word(6'(32 + j), pk(mb[j][0], mb[j][1], mb[j][2], mb[j][3]));
      run_capture(-1, -1, 64'd0, 1'b0, 64'd0);
      checks++;
      if (ov_cnt !== 16) begin
        failures++;
        $display("FAIL rnd_valid run=%0d got=%0d want=16", run, ov_cnt);
      end
      for (int s = 0; s < 16; s++) begin
        bad_k = -1;
        for (int k = 0; k < 8; k++)
          if (bad_k < 0 && cap_w[s][k] !== exp_west(k, s)) bad_k = k;
        checks++;
        if (bad_k >= 0) begin
          failures++;
          $display("FAIL rnd_west run=%0d t=%0d lane=%0d got=%h want=%h",
                   run, s, bad_k, cap_w[s][bad_k], exp_west(bad_k, s));
        end
        bad_k = -1;
        for (int k = 0; k < 8; k++)
          if (bad_k < 0 && cap_n[s][k] !== exp_north(k, s)) bad_k = k;
        checks++;
        if (bad_k >= 0) begin
          failures++;
          $display("FAIL rnd_north run=%0d t=%0d lane=%0d got=%h want=%h",
                   run, s, bad_k, cap_n[s][bad_k], exp_north(bad_k, s));
        end
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) acc[r][c] = 16'd0;
      for (int k = 0; k < 8; k++)
        for (int t = 0; t < 22; t++)
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              if (t - c >= 0 && t - c < 16 && t - r >= 0 && t - r < 16)
                acc[r][c] = acc[r][c] +
                  el(cap_w[t-c][k], r) * el(cap_n[t-r][k], c);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          ref_v = 16'd0;
          for (int j = 0; j < 32; j++)
            ref_v = ref_v + ma[r][j] * mb[j][c];
          checks++;
          if (acc[r][c] !== ref_v) begin
            failures++;
            $display("FAIL rnd_product run=%0d r=%0d c=%0d got=%h want=%h",
                     run, r, c, acc[r][c], ref_v);
          end
        end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 6'd0;
    bus.wr_data  = 64'd0;
    bus.start    = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_a_skew();
    test_b_skew();
    test_back_to_back();
    test_handshake();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
